// File: rtl/gpu_cmd_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : gpu_cmd_sequencer
// Brief    : Command FIFO plus issue/wait/gap sequencer for gpu_top, with a
//            WAIT watchdog and a completion counter. The optional CLEAR phase,
//            which pulses gpu_soft_rst after each command, is enabled by
//            GPU_SEQ_CLEAR_EN.
// Revision : 1.0 - initial release
// ============================================================================
module gpu_cmd_sequencer #(
    parameter int CMD_W          = 128,
    parameter int DEPTH          = 16,
    parameter int GAP_CYCLES     = 5,
    parameter int CLR_CYCLES     = 2,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [CMD_W-1:0]       in_data,
    input  logic                   flush,
    output logic                   gpu_cmd_valid,
    output logic [CMD_W-1:0]       gpu_cmd_data,
    input  logic                   gpu_cmd_ready,
    input  logic                   gpu_done,
    output logic                   gpu_soft_rst,
    output logic                   seq_busy,
    output logic [$clog2(DEPTH):0] fifo_level,
    output logic [15:0]            cmd_count,
    output logic                   timeout_err
);
    localparam int c_AW    = $clog2(DEPTH);
    localparam int c_MAX1  = (TIMEOUT_CYCLES > GAP_CYCLES) ? TIMEOUT_CYCLES : GAP_CYCLES;
    localparam int c_MAX2  = (c_MAX1 > CLR_CYCLES) ? c_MAX1 : CLR_CYCLES;
    localparam int c_TMR_W = $clog2(c_MAX2 + 2);

    localparam logic [c_TMR_W-1:0] c_WD_LAST  = c_TMR_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
    localparam logic [c_TMR_W-1:0] c_GAP_LAST = c_TMR_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic [c_AW:0]      c_FULL     = (c_AW + 1)'(DEPTH);

    localparam logic [2:0] c_S_IDLE  = 3'd0;
    localparam logic [2:0] c_S_ISSUE = 3'd1;
    localparam logic [2:0] c_S_WAIT  = 3'd2;
    localparam logic [2:0] c_S_GAP   = 3'd3;
`ifdef GPU_SEQ_CLEAR_EN
    localparam logic [2:0]         c_S_CLEAR  = 3'd4;
    localparam logic [c_TMR_W-1:0] c_CLR_LAST = c_TMR_W'((CLR_CYCLES > 0) ? CLR_CYCLES - 1 : 0);
`endif

    logic [CMD_W-1:0]   r_mem [DEPTH];
    logic [c_AW-1:0]    r_wr_ptr;
    logic [c_AW-1:0]    r_rd_ptr;
    logic [c_AW:0]      r_level;
    logic [c_AW:0]      w_level_nxt;
    logic               r_full;
    logic               w_push;
    logic               w_pop;

    logic [2:0]         r_state;
    logic [2:0]         w_state_nxt;
    logic [c_TMR_W-1:0] r_tmr;
    logic [c_TMR_W-1:0] w_tmr_nxt;
    logic               r_done_q;
    logic               r_cmd_valid;
    logic               w_valid_nxt;
    logic [CMD_W-1:0]   r_cmd_data;
    logic [15:0]        r_cmd_count;
    logic               w_cmd_done;
    logic               r_timeout;
    logic               w_timeout_set;
    logic               r_busy;

    // Flush wins over a same-cycle push; a same-cycle pop still issues its head.
    assign w_push = in_valid && !r_full && !flush;

    always_comb begin
        w_level_nxt = r_level;
        if (flush) begin
            w_level_nxt = '0;
        end else if (w_push && !w_pop) begin
            w_level_nxt = r_level + (c_AW + 1)'(1);
        end else if (!w_push && w_pop) begin
            w_level_nxt = r_level - (c_AW + 1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= in_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
            r_full   <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_AW'(1);
            end
            if (flush) begin
                r_rd_ptr <= r_wr_ptr;
            end else if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_AW'(1);
            end
            r_level <= w_level_nxt;
            r_full  <= (w_level_nxt == c_FULL);
        end
    end

`ifdef GPU_SEQ_CLEAR_EN
    logic r_soft_rst;
    logic w_soft_rst_nxt;
`endif

    // One timer serves the watchdog, the gap count and the clear pulse.
    always_comb begin
        w_state_nxt   = r_state;
        w_tmr_nxt     = r_tmr;
        w_valid_nxt   = 1'b0;
        w_pop         = 1'b0;
        w_cmd_done    = 1'b0;
        w_timeout_set = 1'b0;
`ifdef GPU_SEQ_CLEAR_EN
        w_soft_rst_nxt = 1'b0;
`endif
        case (r_state)
            c_S_IDLE: begin
                if ((r_level != '0) && gpu_cmd_ready) begin
                    w_pop       = 1'b1;
                    w_valid_nxt = 1'b1;
                    w_state_nxt = c_S_ISSUE;
                end
            end
            c_S_ISSUE: begin
                w_state_nxt = c_S_WAIT;
                w_tmr_nxt   = '0;
            end
            c_S_WAIT: begin
                if (gpu_done && !r_done_q) begin
                    w_cmd_done  = 1'b1;
                    w_state_nxt = c_S_GAP;
                    w_tmr_nxt   = '0;
                end else if ((TIMEOUT_CYCLES > 0) && (r_tmr == c_WD_LAST)) begin
                    w_timeout_set = 1'b1;
                    w_cmd_done    = 1'b1;
                    w_state_nxt   = c_S_GAP;
                    w_tmr_nxt     = '0;
                end else begin
                    w_tmr_nxt = r_tmr + c_TMR_W'(1);
                end
            end
            c_S_GAP: begin
                if ((GAP_CYCLES == 0) || (r_tmr == c_GAP_LAST)) begin
`ifdef GPU_SEQ_CLEAR_EN
                    w_state_nxt    = c_S_CLEAR;
                    w_tmr_nxt      = '0;
                    w_soft_rst_nxt = 1'b1;
`else
                    w_state_nxt = c_S_IDLE;
`endif
                end else begin
                    w_tmr_nxt = r_tmr + c_TMR_W'(1);
                end
            end
`ifdef GPU_SEQ_CLEAR_EN
            c_S_CLEAR: begin
                if (r_tmr == c_CLR_LAST) begin
                    w_state_nxt = c_S_IDLE;
                end else begin
                    w_tmr_nxt      = r_tmr + c_TMR_W'(1);
                    w_soft_rst_nxt = 1'b1;
                end
            end
`endif
            default: begin
                w_state_nxt = c_S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= c_S_IDLE;
            r_tmr       <= '0;
            r_done_q    <= 1'b0;
            r_cmd_valid <= 1'b0;
            r_cmd_data  <= '0;
            r_cmd_count <= '0;
            r_timeout   <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_tmr       <= w_tmr_nxt;
            r_done_q    <= gpu_done;
            r_cmd_valid <= w_valid_nxt;
            if (w_pop) begin
                r_cmd_data <= r_mem[r_rd_ptr];
            end
            if (w_cmd_done) begin
                r_cmd_count <= r_cmd_count + 16'd1;
            end
            if (w_timeout_set) begin
                r_timeout <= 1'b1;
            end
            r_busy <= (w_state_nxt != c_S_IDLE) || (w_level_nxt != '0);
        end
    end

`ifdef GPU_SEQ_CLEAR_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_soft_rst <= 1'b0;
        end else begin
            r_soft_rst <= w_soft_rst_nxt;
        end
    end
    assign gpu_soft_rst = r_soft_rst;
`else
    assign gpu_soft_rst = 1'b0;
`endif

    assign in_ready      = !r_full;
    assign gpu_cmd_valid = r_cmd_valid;
    assign gpu_cmd_data  = r_cmd_data;
    assign seq_busy      = r_busy;
    assign fifo_level    = r_level;
    assign cmd_count     = r_cmd_count;
    assign timeout_err   = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_gpu_cmd_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_gpu_cmd_sequencer
// Brief    : Directed and randomized checks of gpu_cmd_sequencer against a
//            queue-based reference model (follows GPU_SEQ_CLEAR_EN if set).
// Revision : 1.0 - initial release
// ============================================================================
module tb_gpu_cmd_sequencer;
    localparam int CMD_W          = 128;
    localparam int DEPTH          = 16;
    localparam int GAP_CYCLES     = 5;
    localparam int CLR_CYCLES     = 2;
    localparam int TIMEOUT_CYCLES = 64;
`ifdef GPU_SEQ_CLEAR_EN
    localparam int SETTLE = GAP_CYCLES + CLR_CYCLES;
`else
    localparam int SETTLE = GAP_CYCLES;
`endif

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic                   in_valid;
    logic                   in_ready;
    logic [CMD_W-1:0]       in_data;
    logic                   flush;
    logic                   gpu_cmd_valid;
    logic [CMD_W-1:0]       gpu_cmd_data;
    logic                   gpu_cmd_ready;
    logic                   gpu_done;
    logic                   gpu_soft_rst;
    logic                   seq_busy;
    logic [$clog2(DEPTH):0] fifo_level;
    logic [15:0]            cmd_count;
    logic                   timeout_err;

    gpu_cmd_sequencer #(
        .CMD_W          (CMD_W),
        .DEPTH          (DEPTH),
        .GAP_CYCLES     (GAP_CYCLES),
        .CLR_CYCLES     (CLR_CYCLES),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_data       (in_data),
        .flush         (flush),
        .gpu_cmd_valid (gpu_cmd_valid),
        .gpu_cmd_data  (gpu_cmd_data),
        .gpu_cmd_ready (gpu_cmd_ready),
        .gpu_done      (gpu_done),
        .gpu_soft_rst  (gpu_soft_rst),
        .seq_busy      (seq_busy),
        .fifo_level    (fifo_level),
        .cmd_count     (cmd_count),
        .timeout_err   (timeout_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: expected issue order, occupancy and counters.
    logic [CMD_W-1:0] model_q [$];
    int model_level     = 0;
    int exp_count       = 0;
    int exp_pulses      = 0;
    int exp_completions = 0;

    // Output monitor: issue pulses and soft-reset pulse widths.
    int   pulses     = 0;
    int   dbl        = 0;
    int   soft_high  = 0;
    int   run        = 0;
    int   widths_n   = 0;
    int   widths_bad = 0;
    logic prev_v     = 1'b0;

    always @(negedge clk) begin
        if (gpu_cmd_valid) begin
            pulses++;
            if (prev_v) dbl++;
        end
        prev_v = gpu_cmd_valid;
        if (gpu_soft_rst) begin
            soft_high++;
            run++;
        end else if (run != 0) begin
            widths_n++;
            if (run != CLR_CYCLES) widths_bad++;
            run = 0;
        end
    end

    task automatic check(input string tag, input logic [CMD_W-1:0] obs, input logic [CMD_W-1:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    function automatic logic [CMD_W-1:0] rand_cmd();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic push_cmd(input logic [CMD_W-1:0] d);
        in_valid = 1'b1;
        in_data  = d;
        if (model_level < DEPTH) begin
            model_q.push_back(d);
            model_level++;
        end
        tick();
        in_valid = 1'b0;
    endtask

    task automatic expect_issue(input string tag);
        int n = 0;
        logic [CMD_W-1:0] e;
        while (!gpu_cmd_valid && n < 200) begin
            tick();
            n++;
        end
        check({tag, "_issue"}, CMD_W'(gpu_cmd_valid), CMD_W'(1));
        if (gpu_cmd_valid) begin
            exp_pulses++;
            model_level--;
            e = (model_q.size() != 0) ? model_q.pop_front() : '0;
            check({tag, "_data"}, gpu_cmd_data, e);
        end
    endtask

    task automatic finish_cmd(input string tag, input int d);
        repeat (d) tick();
        gpu_done = 1'b1;
        tick();
        exp_count++;
        exp_completions++;
        check({tag, "_count"}, CMD_W'(cmd_count), CMD_W'(16'(exp_count)));
        gpu_done = 1'b0;
    endtask

    task automatic serve(input string tag, input int d);
        expect_issue(tag);
        finish_cmd(tag, d);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_in_ready"},    CMD_W'(in_ready),      CMD_W'(1));
        check({tag, "_cmd_valid"},   CMD_W'(gpu_cmd_valid), CMD_W'(0));
        check({tag, "_cmd_data"},    gpu_cmd_data,          '0);
        check({tag, "_soft_rst"},    CMD_W'(gpu_soft_rst),  CMD_W'(0));
        check({tag, "_busy"},        CMD_W'(seq_busy),      CMD_W'(0));
        check({tag, "_level"},       CMD_W'(fifo_level),    CMD_W'(0));
        check({tag, "_cmd_count"},   CMD_W'(cmd_count),     CMD_W'(0));
        check({tag, "_timeout_err"}, CMD_W'(timeout_err),   CMD_W'(0));
    endtask

    initial begin
        #1000000;
        $fatal(1, "FAIL global_timeout observed=running expected=finished");
    end

    initial begin
        logic [CMD_W-1:0] c1;
        int n;
        rst_n         = 1'b0;
        in_valid      = 1'b0;
        in_data       = '0;
        flush         = 1'b0;
        gpu_cmd_ready = 1'b1;
        gpu_done      = 1'b0;
        repeat (3) tick();
        check_reset_vals("rst");
        rst_n = 1'b1;
        tick();

        // Single draw command: op=2, (20,20)-(30,100), filled, colour FF00FF.
        c1 = {4'd2, 12'd20, 12'd20, 12'd30, 12'd100, 1'b1, 24'hFF00FF, 51'd0};
        in_valid = 1'b1;
        in_data  = c1;
        model_q.push_back(c1);
        model_level++;
        tick();
        in_valid = 1'b0;
        check("t1_level", CMD_W'(fifo_level), CMD_W'(1));
        check("t1_busy", CMD_W'(seq_busy), CMD_W'(1));
        check("t1_early", CMD_W'(gpu_cmd_valid), CMD_W'(0));
        tick();
        check("t1_latency", CMD_W'(gpu_cmd_valid), CMD_W'(1));
        expect_issue("t1");
        tick();
        check("t1_one_pulse", CMD_W'(gpu_cmd_valid), CMD_W'(0));
        finish_cmd("t1", 39);
        repeat (SETTLE - 1) tick();
        check("t1_busy_gap", CMD_W'(seq_busy), CMD_W'(1));
        tick();
        check("t1_busy_drop", CMD_W'(seq_busy), CMD_W'(0));

        // Fill to DEPTH, 17th push refused, drain in order.
        gpu_cmd_ready = 1'b0;
        for (int i = 0; i < DEPTH + 1; i++) begin
            push_cmd(rand_cmd());
            check("t2_level", CMD_W'(fifo_level), CMD_W'(model_level));
            if (i == DEPTH - 1) check("t2_full", CMD_W'(in_ready), CMD_W'(0));
        end
        check("t2_still_full", CMD_W'(in_ready), CMD_W'(0));
        gpu_cmd_ready = 1'b1;
        for (int i = 0; i < DEPTH; i++) serve("t2", $urandom_range(1, 12));
        check("t2_level_end", CMD_W'(fifo_level), CMD_W'(0));
        repeat (SETTLE + 2) tick();

        // Stale high done level must not complete the command.
        gpu_done = 1'b1;
        repeat (2) tick();
        push_cmd(rand_cmd());
        expect_issue("t3");
        repeat (10) tick();
        check("t3_hold", CMD_W'(cmd_count), CMD_W'(16'(exp_count)));
        gpu_done = 1'b0;
        finish_cmd("t3", 2);
        repeat (SETTLE + 2) tick();

        // Watchdog expiry, then the next command still issues.
        push_cmd(rand_cmd());
        push_cmd(rand_cmd());
        expect_issue("t4");
        repeat (TIMEOUT_CYCLES) tick();
        check("t4_not_yet", CMD_W'(timeout_err), CMD_W'(0));
        tick();
        check("t4_timeout", CMD_W'(timeout_err), CMD_W'(1));
        exp_count++;
        exp_completions++;
        check("t4_count", CMD_W'(cmd_count), CMD_W'(16'(exp_count)));
        serve("t4b", 3);
        check("t4_sticky", CMD_W'(timeout_err), CMD_W'(1));
        repeat (SETTLE + 2) tick();

        // Flush during WAIT: in-flight command completes, the rest are dropped.
        gpu_cmd_ready = 1'b0;
        for (int i = 0; i < 5; i++) push_cmd(rand_cmd());
        check("t5_level", CMD_W'(fifo_level), CMD_W'(5));
        gpu_cmd_ready = 1'b1;
        expect_issue("t5");
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        model_q.delete();
        model_level = 0;
        check("t5_flush_level", CMD_W'(fifo_level), CMD_W'(0));
        finish_cmd("t5", 2);
        repeat (60) tick();
        check("t5_no_issue", CMD_W'(pulses), CMD_W'(exp_pulses));
        check("t5_idle", CMD_W'(seq_busy), CMD_W'(0));

        // Asynchronous reset in the middle of WAIT.
        push_cmd(rand_cmd());
        expect_issue("t6");
        repeat (2) tick();
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_vals("t6");
        model_q.delete();
        model_level = 0;
        exp_count   = 0;
        tick();
        rst_n = 1'b1;
        repeat (10) tick();
        check("t6_no_valid", CMD_W'(gpu_cmd_valid), CMD_W'(0));
        check("t6_no_soft_rst", CMD_W'(gpu_soft_rst), CMD_W'(0));
        check("t6_idle", CMD_W'(seq_busy), CMD_W'(0));

        // Randomized batches with random push gaps and done delays.
        for (int r = 0; r < 10; r++) begin
            gpu_cmd_ready = 1'b0;
            n = $urandom_range(1, 8);
            for (int j = 0; j < n; j++) begin
                if ($urandom_range(0, 3) == 0) tick();
                push_cmd(rand_cmd());
            end
            check("t7_level", CMD_W'(fifo_level), CMD_W'(model_level));
            gpu_cmd_ready = 1'b1;
            for (int j = 0; j < n; j++) serve("t7", $urandom_range(1, 30));
            repeat (SETTLE + 2) tick();
        end

        repeat (20) tick();
        check("pulse_total", CMD_W'(pulses), CMD_W'(exp_pulses));
        check("no_double_pulse", CMD_W'(dbl), CMD_W'(0));
`ifdef GPU_SEQ_CLEAR_EN
        check("clr_pulse_count", CMD_W'(widths_n), CMD_W'(exp_completions));
        check("clr_width_bad", CMD_W'(widths_bad), CMD_W'(0));
        check("clr_cycles_total", CMD_W'(soft_high), CMD_W'(exp_completions * CLR_CYCLES));
`else
        check("soft_rst_never", CMD_W'(soft_high), CMD_W'(0));
        check("soft_rst_pulses", CMD_W'(widths_n + widths_bad), CMD_W'(0));
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
